// File: rtl/addr_alu_datapath.sv
// Purpose: 65C02 address generation (ABL/ABH/PC/AHL) plus combinational 8-bit ALU.
// Latency: AD, abl_co, pcl_co and ALU outputs are combinational; ABL/ABH/AHL/PC update on clk.
// Backpressure: none; the microcode controller sequences every cycle.
//
// Ports:
//   clk, RST          rising-edge clock, synchronous active-low reset
//   abl_op, abl_ci    ABL base/index select and adder carry-in
//   abh_op, abh_ff    ABH carry source/base select, force vector page FF
//   ld_ahl            capture DB into the AHL holding register
//   ld_pc, inc_pc     load PC from current address, increment PC
//   DB, R, M          data bus, register-file read value, memory operand
//   alu_op, alu_ci,   ALU function/shift select, carry-in, shift-in bit
//   alu_si
//   AD                address bus {ADH, ADL} (combinational)
//   PC                program counter {PCH, PCL} (registered)
//   abl_co, pcl_co    ABL adder carry-out, PCL increment carry
//   alu_out, alu_co,  ALU result, carry-out, overflow
//   alu_v
module addr_alu_datapath (
  input  logic        clk,
  input  logic        RST,
  input  logic [3:0]  abl_op,
  input  logic        abl_ci,
  input  logic [2:0]  abh_op,
  input  logic        abh_ff,
  input  logic        ld_ahl,
  input  logic        ld_pc,
  input  logic        inc_pc,
  input  logic [7:0]  DB,
  input  logic [7:0]  R,
  input  logic [7:0]  M,
  input  logic [4:0]  alu_op,
  input  logic        alu_ci,
  input  logic        alu_si,
  output logic [15:0] AD,
  output logic [15:0] PC,
  output logic        abl_co,
  output logic        pcl_co,
  output logic [7:0]  alu_out,
  output logic        alu_co,
  output logic        alu_v
);

  // ALU function codes (alu_op[4:2])
  localparam logic [2:0] FN_OR   = 3'b000;
  localparam logic [2:0] FN_AND  = 3'b001;
  localparam logic [2:0] FN_XOR  = 3'b010;
  localparam logic [2:0] FN_ADD  = 3'b011;
  localparam logic [2:0] FN_SUB  = 3'b100;
  localparam logic [2:0] FN_PASR = 3'b101;
  localparam logic [2:0] FN_PASM = 3'b110;
  localparam logic [2:0] FN_ZERO = 3'b111;

  // ALU shift codes (alu_op[1:0])
  localparam logic [1:0] SH_LEFT  = 2'b01;
  localparam logic [1:0] SH_RIGHT = 2'b10;

  // Architectural state
  logic [7:0] abl_q;
  logic [7:0] abh_q;
  logic [7:0] ahl_q;
  logic [7:0] pcl_q;
  logic [7:0] pch_q;

  // ------------------------------------------------------------------
  // Address bus low
  // ------------------------------------------------------------------
  logic [7:0] base_l;
  logic [7:0] idx_l;
  logic [8:0] abl_sum;
  logic [7:0] adl;

  always_comb begin
    base_l = abl_q;
    case (abl_op[3:2])
      2'b00:   base_l = abl_q;
      2'b01:   base_l = pcl_q;
      2'b10:   base_l = DB;
      default: base_l = ahl_q;
    endcase
  end

  always_comb begin
    idx_l = 8'h00;
    case (abl_op[1:0])
      2'b00:   idx_l = 8'h00;
      2'b01:   idx_l = R;
      2'b10:   idx_l = DB;
      default: idx_l = ahl_q;
    endcase
  end

  assign abl_sum = {1'b0, base_l} + {1'b0, idx_l} + {8'h00, abl_ci};
  assign adl     = abl_sum[7:0];
  assign abl_co  = abl_sum[8];

  // ------------------------------------------------------------------
  // Address bus high
  // ------------------------------------------------------------------
  logic [7:0] base_h;
  logic       abh_ci;
  logic [7:0] adh;

  // Without the ABL carry, abh_op[1] doubles as a constant +1 so that
  // DB+1 (page crossing of a zero-page pointer) and page 01 (stack)
  // come out of the same incrementer.
  assign abh_ci = abh_op[2] ? abl_co : abh_op[1];

  always_comb begin
    base_h = abh_q;
    case (abh_op[1:0])
      2'b00:   base_h = abh_q;
      2'b01:   base_h = pch_q;
      2'b10:   base_h = DB;
      default: base_h = 8'h00;
    endcase
  end

  assign adh = abh_ff ? 8'hFF : (base_h + {7'h00, abh_ci});
  assign AD  = {adh, adl};

  // ------------------------------------------------------------------
  // Program counter
  // ------------------------------------------------------------------
  logic [7:0] pcl_src;
  logic [7:0] pch_src;
  logic [7:0] pcl_next;
  logic [7:0] pch_next;

  assign pcl_src  = ld_pc ? adl : pcl_q;
  assign pch_src  = ld_pc ? adh : pch_q;
  assign pcl_co   = inc_pc & (pcl_src == 8'hFF);
  assign pcl_next = pcl_src + {7'h00, inc_pc};
  assign pch_next = pch_src + {7'h00, pcl_co};
  assign PC       = {pch_q, pcl_q};

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!RST) begin
      abl_q <= 8'h00;
      abh_q <= 8'h00;
      ahl_q <= 8'h00;
      pcl_q <= 8'h00;
      pch_q <= 8'h00;
    end else begin
      abl_q <= adl;
      abh_q <= adh;
      pcl_q <= pcl_next;
      pch_q <= pch_next;
      if (ld_ahl) begin
        ahl_q <= DB;
      end
    end
  end

  // ------------------------------------------------------------------
  // ALU
  // ------------------------------------------------------------------
  logic [2:0] alu_fn;
  logic [1:0] alu_sh;
  logic       is_arith;
  logic [7:0] alu_b;
  logic [8:0] alu_sum;
  logic [7:0] alu_p;

  assign alu_fn   = alu_op[4:2];
  assign alu_sh   = alu_op[1:0];
  assign is_arith = (alu_fn == FN_ADD) || (alu_fn == FN_SUB);

  // Subtract is R + ~M + ci, so carry out means "no borrow".
  assign alu_b   = (alu_fn == FN_SUB) ? ~M : M;
  assign alu_sum = {1'b0, R} + {1'b0, alu_b} + {8'h00, alu_ci};

  always_comb begin
    alu_p = 8'h00;
    case (alu_fn)
      FN_OR:   alu_p = R | M;
      FN_AND:  alu_p = R & M;
      FN_XOR:  alu_p = R ^ M;
      FN_ADD:  alu_p = alu_sum[7:0];
      FN_SUB:  alu_p = alu_sum[7:0];
      FN_PASR: alu_p = R;
      FN_PASM: alu_p = M;
      FN_ZERO: alu_p = 8'h00;
      default: alu_p = 8'h00;
    endcase
  end

  // Overflow is judged on the pre-shift result, even when a shift follows.
  assign alu_v = is_arith & (R[7] == alu_b[7]) & (alu_p[7] != R[7]);

  always_comb begin
    alu_out = alu_p;
    alu_co  = is_arith & alu_sum[8];
    case (alu_sh)
      SH_LEFT: begin
        alu_out = {alu_p[6:0], alu_si};
        alu_co  = alu_p[7];
      end
      SH_RIGHT: begin
        alu_out = {alu_si, alu_p[7:1]};
        alu_co  = alu_p[0];
      end
      default: begin
        // 00 and 11 both pass the pre-shift result through
        alu_out = alu_p;
        alu_co  = is_arith & alu_sum[8];
      end
    endcase
  end

endmodule

// File: tb/tb_addr_alu_datapath.sv
// Directed bench for addr_alu_datapath: address generation, PC stepping,
// reset override and ALU functions, each against hand-computed values.
module tb_addr_alu_datapath;

  logic        clk;
  logic        RST;
  logic [3:0]  abl_op;
  logic        abl_ci;
  logic [2:0]  abh_op;
  logic        abh_ff;
  logic        ld_ahl;
  logic        ld_pc;
  logic        inc_pc;
  logic [7:0]  DB;
  logic [7:0]  R;
  logic [7:0]  M;
  logic [4:0]  alu_op;
  logic        alu_ci;
  logic        alu_si;
  logic [15:0] AD;
  logic [15:0] PC;
  logic        abl_co;
  logic        pcl_co;
  logic [7:0]  alu_out;
  logic        alu_co;
  logic        alu_v;

  int n_tests = 0;
  int n_fail  = 0;

  addr_alu_datapath dut (
    .clk     (clk),
    .RST     (RST),
    .abl_op  (abl_op),
    .abl_ci  (abl_ci),
    .abh_op  (abh_op),
    .abh_ff  (abh_ff),
    .ld_ahl  (ld_ahl),
    .ld_pc   (ld_pc),
    .inc_pc  (inc_pc),
    .DB      (DB),
    .R       (R),
    .M       (M),
    .alu_op  (alu_op),
    .alu_ci  (alu_ci),
    .alu_si  (alu_si),
    .AD      (AD),
    .PC      (PC),
    .abl_co  (abl_co),
    .pcl_co  (pcl_co),
    .alu_out (alu_out),
    .alu_co  (alu_co),
    .alu_v   (alu_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; comb outputs are
  // sampled after a further settle delay, well clear of the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    abl_op = 4'b0000; abl_ci = 1'b0; abh_op = 3'b000; abh_ff = 1'b0;
    ld_ahl = 1'b0; ld_pc = 1'b0; inc_pc = 1'b0; DB = 8'h00;
  endtask

  initial begin
    RST = 1'b0;
    idle();
    R = 8'h00; M = 8'h00; alu_op = 5'b00000; alu_ci = 1'b0; alu_si = 1'b0;

    // Reset then idle
    tick();
    RST = 1'b1;
    settle();
    check("reset_pc", PC, 16'h0000);
    check("reset_ad", AD, 16'h0000);

    // ABH <= 12 via ADH = DB (carry source = abl_co, which is 0)
    DB = 8'h12; abl_op = 4'b1000; abh_op = 3'b110;
    settle();
    check("ad_db_db", AD, 16'h1212);
    tick();

    // AD = 12FF, ld_pc + inc_pc -> PC 1300 with page carry
    DB = 8'hFF; abl_op = 4'b1000; abh_op = 3'b000; ld_pc = 1'b1; inc_pc = 1'b1;
    settle();
    check("ad_12ff", AD, 16'h12FF);
    check("pcl_co_page", {15'h0, pcl_co}, 16'h0001);
    tick();
    check("pc_page_cross", PC, 16'h1300);

    // Plain increment, no page carry
    idle(); inc_pc = 1'b1;
    settle();
    check("pcl_co_none", {15'h0, pcl_co}, 16'h0000);
    tick();
    check("pc_inc", PC, 16'h1301);

    // ABH <= 34
    idle(); DB = 8'h34; abl_op = 4'b1000; abh_op = 3'b110;
    tick();

    // Indexed DB+R with carry: only propagates when abh_op[2]=1
    idle(); DB = 8'hF0; R = 8'h20; abl_op = 4'b1001; abh_op = 3'b000;
    settle();
    check("idx_no_prop", AD, 16'h3410);
    check("idx_abl_co", {15'h0, abl_co}, 16'h0001);
    abh_op = 3'b100;
    settle();
    check("idx_prop", AD, 16'h3510);
    abl_ci = 1'b1;
    settle();
    check("idx_ci", AD, 16'h3511);

    // Vector / stack / DB+1 pages
    abl_ci = 1'b0; abh_ff = 1'b1;
    settle();
    check("vector_page", {8'h00, AD[15:8]}, 16'h00FF);
    abh_ff = 1'b0; abh_op = 3'b011;
    settle();
    check("stack_page", {8'h00, AD[15:8]}, 16'h0001);
    abh_op = 3'b010;
    settle();
    check("db_plus1", {8'h00, AD[15:8]}, 16'h00F1);

    // AHL capture, then ADL = AHL and ADL = ABL + AHL (ABL still 34)
    idle(); ld_ahl = 1'b1; DB = 8'h5A;
    tick();
    idle(); abl_op = 4'b1100;
    settle();
    check("ahl_base", {8'h00, AD[7:0]}, 16'h005A);
    abl_op = 4'b0011;
    settle();
    check("abl_plus_ahl", {8'h00, AD[7:0]}, 16'h008E);
    check("pc_hold", PC, 16'h1301);

    // PC wrap FFFF -> 0000
    idle(); DB = 8'hFF; abl_op = 4'b1000; abh_ff = 1'b1; ld_pc = 1'b1;
    tick();
    check("pc_load_ffff", PC, 16'hFFFF);
    idle(); inc_pc = 1'b1;
    settle();
    check("pcl_co_wrap", {15'h0, pcl_co}, 16'h0001);
    tick();
    check("pc_wrap", PC, 16'h0000);
    tick();
    check("pc_after_wrap", PC, 16'h0001);

    // Reset overrides ld_pc / inc_pc / ld_ahl
    idle(); RST = 1'b0; ld_pc = 1'b1; inc_pc = 1'b1; ld_ahl = 1'b1;
    DB = 8'h77; abl_op = 4'b1000;
    tick();
    RST = 1'b1; idle();
    settle();
    check("rst_override_pc", PC, 16'h0000);
    check("rst_override_ad", AD, 16'h0000);
    abl_op = 4'b1100;
    settle();
    check("rst_clears_ahl", {8'h00, AD[7:0]}, 16'h0000);
    idle();

    // ALU: add with signed overflow
    R = 8'h7F; M = 8'h01; alu_op = 5'b01100; alu_ci = 1'b0; alu_si = 1'b0;
    settle();
    check("add_out", {8'h00, alu_out}, 16'h0080);
    check("add_v", {15'h0, alu_v}, 16'h0001);
    check("add_co", {15'h0, alu_co}, 16'h0000);

    // Subtract equal values: zero, no borrow
    R = 8'h05; M = 8'h05; alu_op = 5'b10000; alu_ci = 1'b1;
    settle();
    check("sub_out", {8'h00, alu_out}, 16'h0000);
    check("sub_co", {15'h0, alu_co}, 16'h0001);
    check("sub_v", {15'h0, alu_v}, 16'h0000);

    // Subtract with borrow: 03 - 05 = FE, carry clear
    R = 8'h03; M = 8'h05;
    settle();
    check("sub_borrow_out", {8'h00, alu_out}, 16'h00FE);
    check("sub_borrow_co", {15'h0, alu_co}, 16'h0000);

    // Subtract signed overflow: 80 - 01 = 7F
    R = 8'h80; M = 8'h01;
    settle();
    check("sub_ovf_out", {8'h00, alu_out}, 16'h007F);
    check("sub_ovf_v", {15'h0, alu_v}, 16'h0001);

    // Add then shift left: P=00 (carry lost), CO from P[7], V pre-shift
    R = 8'h80; M = 8'h80; alu_op = 5'b01101; alu_ci = 1'b0; alu_si = 1'b0;
    settle();
    check("add_shl_out", {8'h00, alu_out}, 16'h0000);
    check("add_shl_co", {15'h0, alu_co}, 16'h0000);
    check("add_shl_v", {15'h0, alu_v}, 16'h0001);

    // Pass R with left shift
    R = 8'h81; alu_op = 5'b10101; alu_si = 1'b1;
    settle();
    check("shl_out", {8'h00, alu_out}, 16'h0003);
    check("shl_co", {15'h0, alu_co}, 16'h0001);

    // Pass M with right shift
    M = 8'h01; alu_op = 5'b11010; alu_si = 1'b0;
    settle();
    check("shr_out", {8'h00, alu_out}, 16'h0000);
    check("shr_co", {15'h0, alu_co}, 16'h0001);

    // OR with shift code 11 behaves as unshifted; logic ops give CO=0
    R = 8'hF0; M = 8'h0F; alu_op = 5'b00011; alu_si = 1'b1;
    settle();
    check("or_sh11_out", {8'h00, alu_out}, 16'h00FF);
    check("or_sh11_co", {15'h0, alu_co}, 16'h0000);

    // AND / XOR / zero
    R = 8'hCC; M = 8'hAA; alu_op = 5'b00100;
    settle();
    check("and_out", {8'h00, alu_out}, 16'h0088);
    alu_op = 5'b01000;
    settle();
    check("xor_out", {8'h00, alu_out}, 16'h0066);
    check("xor_v", {15'h0, alu_v}, 16'h0000);
    alu_op = 5'b11100;
    settle();
    check("zero_out", {8'h00, alu_out}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
